sie_rx_bit_decoder: RTL and testbench

Consumes the oversampled, clock-recovered USB line symbols produced by the wire-sampling stage (2-bit {D+,D-} symbol plus wire-active qualifier, one write per USB bit period). Detects SYNC, NRZI-decodes, removes stuffed bits, assembles LSB-first bytes and detects EOP. Delivers bytes and per-packet start/end/error status to the SIE packet receiver. Sits between the wire reader and the SIE receive packet engine in the serial interface engine.

---
 rtl/sie_rx_bit_decoder_pkg.sv | 46 ++++
 rtl/sie_rx_bit_decoder_nrzi.sv | 58 +++++
 rtl/sie_rx_bit_decoder.sv | 180 ++++++++++++++++++
 tb/tb_sie_rx_bit_decoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sie_rx_bit_decoder_pkg.sv
// Shared definitions for the SIE receive bit decoder:
// line symbol codes, FSM states, error flag indices, stuff limit.
package sie_rx_bit_decoder_pkg;

    localparam logic [1:0] SE0  = 2'b00;
    localparam logic [1:0] SE1  = 2'b11;
    localparam logic [1:0] FS_J = 2'b10;
    localparam logic [1:0] FS_K = 2'b01;
    localparam logic [1:0] LS_J = 2'b01;
    localparam logic [1:0] LS_K = 2'b10;

    localparam int STUFF_LIMIT = 6;

    localparam int ERR_STUFF = 0;
    localparam int ERR_ALIGN = 1;
    localparam int ERR_LINE  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP
    } rx_state_e;

    typedef enum logic [1:0] {
        SYM_J,
        SYM_K,
        SYM_SE0,
        SYM_SE1
    } sym_cls_e;

    function automatic sym_cls_e classify(input logic [1:0] sym,
                                          input logic       fs);
        sym_cls_e c;
        if (sym == SE0)
            c = SYM_SE0;
        else if (sym == SE1)
            c = SYM_SE1;
        else if (sym == (fs ? FS_J : LS_J))
            c = SYM_J;
        else
            c = SYM_K;
        return c;
    endfunction

endpackage

// File: rtl/sie_rx_bit_decoder_nrzi.sv
// Symbol classification, NRZI decode and bit-unstuffing bookkeeping.
// Previous symbol is kept as a J/K flag so it is independent of line speed.
module rx_nrzi_unstuff
    import sie_rx_bit_decoder_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       fs_i,
    input  logic [1:0] sym_i,
    input  logic       sym_en_i,
    input  logic       prev_reload_i,
    input  logic       ones_load_i,
    input  logic       ones_upd_i,
    output sym_cls_e   cls_o,
    output logic       bit_o,
    output logic       stuff_o,
    output logic       stuff_err_o
);

    logic       prev_j_q;
    logic       prev_j_d;
    logic [2:0] ones_q;
    logic [2:0] ones_d;
    logic       is_jk;
    logic       at_limit;

    assign cls_o       = classify(sym_i, fs_i);
    assign is_jk       = (cls_o == SYM_J) || (cls_o == SYM_K);
    assign bit_o       = ((cls_o == SYM_J) == prev_j_q);
    assign at_limit    = (ones_q == 3'(STUFF_LIMIT));
    assign stuff_o     = at_limit && !bit_o;
    assign stuff_err_o = at_limit && bit_o;

    always_comb begin
        prev_j_d = prev_j_q;
        ones_d   = ones_q;
        if (prev_reload_i)
            prev_j_d = 1'b1;
        else if (sym_en_i && is_jk)
            prev_j_d = (cls_o == SYM_J);
        // A violated stuff bit also restarts the run count
        if (ones_load_i)
            ones_d = 3'd1;
        else if (ones_upd_i)
            ones_d = (at_limit || !bit_o) ? 3'd0 : ones_q + 3'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_j_q <= 1'b1;
            ones_q   <= 3'd0;
        end else begin
            prev_j_q <= prev_j_d;
            ones_q   <= ones_d;
        end
    end

endmodule

// File: rtl/sie_rx_bit_decoder.sv
// USB receive bit decoder: SYNC detect, NRZI/unstuff, LSB-first byte
// assembly, EOP detect and per-packet status towards the packet engine.
module sie_rx_bit_decoder
    import sie_rx_bit_decoder_pkg::*;
#(
    parameter int SYNC_MIN_ZEROS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fullSpeedRate,
    input  logic [1:0] RxBitsIn,
    input  logic       RxWireActive,
    input  logic       RxBitsInWEn,
    output logic       RxBitsInRdy,
    output logic [7:0] RxDataOut,
    output logic       RxDataValid,
    output logic       RxPktStart,
    output logic       RxPktEnd,
    output logic [2:0] RxErrFlags,
    output logic       RxActive
);

    localparam logic [2:0] MIN_ZEROS = 3'(SYNC_MIN_ZEROS);

    rx_state_e  state_q, state_d;
    logic       rdy_q, rdy_d;
    logic [2:0] zeros_q, zeros_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       start_q, start_d;
    logic       end_q, end_d;
    logic [2:0] err_q, err_d;
    logic       active_q, active_d;

    logic       accept;
    logic       reload;
    logic       ones_load;
    logic       ones_upd;
    sym_cls_e   cls;
    logic       dbit;
    logic       stuff;
    logic       stuff_err;

    assign accept = RxBitsInWEn && rdy_q;

    rx_nrzi_unstuff u_nrzi (
        .clk_i         (clk),
        .rst_i         (rst),
        .fs_i          (fullSpeedRate),
        .sym_i         (RxBitsIn),
        .sym_en_i      (accept && RxWireActive),
        .prev_reload_i (reload),
        .ones_load_i   (ones_load),
        .ones_upd_i    (ones_upd),
        .cls_o         (cls),
        .bit_o         (dbit),
        .stuff_o       (stuff),
        .stuff_err_o   (stuff_err)
    );

    always_comb begin
        state_d   = state_q;
        rdy_d     = !accept;
        zeros_d   = zeros_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        err_d     = err_q;
        valid_d   = 1'b0;
        start_d   = 1'b0;
        end_d     = 1'b0;
        reload    = 1'b0;
        ones_load = 1'b0;
        ones_upd  = 1'b0;
        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (RxWireActive && cls == SYM_K) begin
                        state_d = ST_SYNC;
                        zeros_d = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (!RxWireActive || cls == SYM_SE0 || cls == SYM_SE1) begin
                        state_d = ST_IDLE;
                        reload  = 1'b1;
                    end else if (!dbit) begin
                        zeros_d = (zeros_q == 3'd7) ? 3'd7 : zeros_q + 3'd1;
                    end else if (zeros_q >= MIN_ZEROS) begin
                        state_d   = ST_DATA;
                        start_d   = 1'b1;
                        ones_load = 1'b1;
                        bcnt_d    = 3'd0;
                        err_d     = 3'b000;
                    end else begin
                        state_d = ST_IDLE;
                        reload  = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (!RxWireActive || cls == SYM_SE1) begin
                        err_d[ERR_LINE] = 1'b1;
                        end_d   = 1'b1;
                        state_d = ST_IDLE;
                        reload  = 1'b1;
                    end else if (cls == SYM_SE0) begin
                        err_d[ERR_ALIGN] = (bcnt_q != 3'd0);
                        state_d = ST_EOP;
                    end else begin
                        ones_upd = 1'b1;
                        if (stuff_err) begin
                            err_d[ERR_STUFF] = 1'b1;
                        end else if (!stuff) begin
                            shift_d = {dbit, shift_q[7:1]};
                            bcnt_d  = bcnt_q + 3'd1;
                            if (bcnt_q == 3'd7 && !err_q[ERR_STUFF]) begin
                                valid_d = 1'b1;
                                data_d  = {dbit, shift_q[7:1]};
                            end
                        end
                    end
                end
                ST_EOP: begin
                    if (!(RxWireActive && cls == SYM_SE0)) begin
                        if (!RxWireActive || cls != SYM_J)
                            err_d[ERR_LINE] = 1'b1;
                        end_d   = 1'b1;
                        state_d = ST_IDLE;
                        reload  = 1'b1;
                    end
                end
            endcase
        end
        // Active covers the end-pulse cycle and drops one cycle later
        active_d = active_q;
        if (start_d)
            active_d = 1'b1;
        else if (end_q)
            active_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rdy_q    <= 1'b1;
            zeros_q  <= 3'd0;
            bcnt_q   <= 3'd0;
            shift_q  <= 8'h00;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            end_q    <= 1'b0;
            err_q    <= 3'b000;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            zeros_q  <= zeros_d;
            bcnt_q   <= bcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            end_q    <= end_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    assign RxBitsInRdy = rdy_q;
    assign RxDataOut   = data_q;
    assign RxDataValid = valid_q;
    assign RxPktStart  = start_q;
    assign RxPktEnd    = end_q;
    assign RxErrFlags  = err_q;
    assign RxActive    = active_q;

endmodule

// File: tb/tb_sie_rx_bit_decoder.sv
// Packets are built from bytes, bit-stuffed and NRZI-encoded here; the
// expected start/byte/end events are queued as each packet is issued.
module tb_sie_rx_bit_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       fullSpeedRate;
    logic [1:0] RxBitsIn;
    logic       RxWireActive;
    logic       RxBitsInWEn;
    logic       RxBitsInRdy;
    logic [7:0] RxDataOut;
    logic       RxDataValid;
    logic       RxPktStart;
    logic       RxPktEnd;
    logic [2:0] RxErrFlags;
    logic       RxActive;

    sie_rx_bit_decoder #(.SYNC_MIN_ZEROS(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .fullSpeedRate (fullSpeedRate),
        .RxBitsIn      (RxBitsIn),
        .RxWireActive  (RxWireActive),
        .RxBitsInWEn   (RxBitsInWEn),
        .RxBitsInRdy   (RxBitsInRdy),
        .RxDataOut     (RxDataOut),
        .RxDataValid   (RxDataValid),
        .RxPktStart    (RxPktStart),
        .RxPktEnd      (RxPktEnd),
        .RxErrFlags    (RxErrFlags),
        .RxActive      (RxActive)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] EV_START = 2'd0;
    localparam logic [1:0] EV_BYTE  = 2'd1;
    localparam logic [1:0] EV_END   = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] val;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pkt[$];
    int         checks = 0;
    int         errors = 0;
    bit         lvl_j = 1'b1;
    int         ones = 0;
    bit         inject_armed = 1'b0;
    bit         dbl_next = 1'b0;
    bit         end_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    function automatic ev_t mk(input logic [1:0] k, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        return e;
    endfunction

    function automatic logic [1:0] sym_j();
        return fullSpeedRate ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] sym_k();
        return fullSpeedRate ? 2'b01 : 2'b10;
    endfunction

    always @(negedge clk) begin
        ev_t got;
        ev_t want;
        if (!rst) begin
            if (end_seen)
                chk("active_fall", RxActive, 1'b0);
            end_seen = RxPktEnd;
            if (RxPktStart || RxDataValid || RxPktEnd) begin
                got.kind = RxPktStart ? EV_START :
                           (RxDataValid ? EV_BYTE : EV_END);
                got.val  = RxPktStart ? 8'h00 :
                           (RxDataValid ? RxDataOut : {5'd0, RxErrFlags});
                chk("active_high", RxActive, 1'b1);
                chk("one_pulse", int'(RxPktStart) + int'(RxDataValid)
                    + int'(RxPktEnd), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got kind %0d val %02h, required none",
                             got.kind, got.val);
                end else begin
                    want = exp_q.pop_front();
                    chk("event", {22'd0, got.kind, got.val},
                        {22'd0, want.kind, want.val});
                end
            end
        end else begin
            end_seen = 1'b0;
        end
    end

    task automatic send_sym(input logic [1:0] s, input logic act);
        @(negedge clk);
        chk("rdy_before", RxBitsInRdy, 1'b1);
        RxBitsIn     = s;
        RxWireActive = act;
        RxBitsInWEn  = 1'b1;
        @(negedge clk);
        if (dbl_next) begin
            // Second strobe carries an abort symbol that must be dropped
            dbl_next = 1'b0;
            chk("rdy_after_accept", RxBitsInRdy, 1'b0);
            RxBitsIn     = 2'b11;
            RxWireActive = 1'b0;
            @(negedge clk);
            chk("rdy_recover", RxBitsInRdy, 1'b1);
        end
        RxBitsInWEn = 1'b0;
        repeat ($urandom_range(3, 5)) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        if (!b)
            lvl_j = !lvl_j;
        send_sym(lvl_j ? sym_j() : sym_k(), 1'b1);
    endtask

    task automatic send_data_bit(input bit b);
        send_bit(b);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
            send_bit(inject_armed);
            inject_armed = 1'b0;
            ones = 0;
        end
    endtask

    task automatic start_pkt(input int zeros);
        send_sym(sym_j(), 1'b1);
        lvl_j = 1'b1;
        repeat (zeros) send_bit(1'b0);
        send_bit(1'b1);
        ones = 1;
    endtask

    task automatic chk_reset();
        chk("rst_rdy", RxBitsInRdy, 1'b1);
        chk("rst_data", RxDataOut, 8'h00);
        chk("rst_valid", RxDataValid, 1'b0);
        chk("rst_start", RxPktStart, 1'b0);
        chk("rst_end", RxPktEnd, 1'b0);
        chk("rst_flags", RxErrFlags, 3'b000);
        chk("rst_active", RxActive, 1'b0);
    endtask

    // mode 0 normal, 1 stuff violation, 2 misaligned, 3 wire drop,
    // 4 short SYNC, 5 double strobe, 6 reset mid-packet
    task automatic run_pkt(input int mode, input int zeros, input int extra);
        int         n;
        int         cut;
        int         rbits;
        logic [2:0] flags;
        logic [7:0] by;
        n     = pkt.size();
        rbits = $urandom_range(0, 7);
        cut   = n;
        if (mode == 3 || mode == 6)
            cut = $urandom_range(0, n - 1);
        if (mode == 1) begin
            pkt[n-1] = 8'hFF;
            if (n > 1) begin
                by = pkt[n-2];
                by[7] = 1'b0;
                pkt[n-2] = by;
            end
        end
        flags = (mode == 1) ? 3'b001 : (mode == 2) ? 3'b010 :
                (mode == 3) ? 3'b100 : 3'b000;
        if (mode != 4) begin
            exp_q.push_back(mk(EV_START, 8'h00));
            for (int i = 0; i < cut; i++)
                if (!(mode == 1 && i == n - 1))
                    exp_q.push_back(mk(EV_BYTE, pkt[i]));
            if (mode != 6)
                exp_q.push_back(mk(EV_END, {5'd0, flags}));
        end
        start_pkt(zeros);
        if (mode == 4) begin
            repeat (2) send_sym(sym_j(), 1'b1);
        end else begin
            dbl_next = (mode == 5);
            for (int i = 0; i < cut; i++) begin
                by = pkt[i];
                if (mode == 1 && i == n - 1)
                    inject_armed = 1'b1;
                for (int b = 0; b < 8; b++)
                    send_data_bit(by[b]);
            end
            if (mode == 2)
                repeat (extra) send_data_bit(1'($urandom));
            if (mode == 3 || mode == 6)
                repeat (rbits) send_data_bit(1'($urandom));
            if (mode == 3) begin
                send_sym(2'($urandom), 1'b0);
            end else if (mode == 6) begin
                @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                chk_reset();
                rst = 1'b0;
            end else begin
                send_sym(2'b00, 1'b1);
                send_sym(2'b00, 1'b1);
                send_sym(sym_j(), 1'b1);
            end
        end
        repeat (4) @(negedge clk);
        chk("drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int mode;
        rst           = 1'b1;
        fullSpeedRate = 1'b1;
        RxBitsIn      = 2'b00;
        RxWireActive  = 1'b0;
        RxBitsInWEn   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        pkt = '{8'hA5};
        run_pkt(0, 7, 0);
        pkt = '{8'h3C};
        run_pkt(0, 5, 0);
        pkt = '{8'hFF};
        run_pkt(0, 7, 0);
        pkt = '{8'hFF};
        run_pkt(1, 7, 0);
        fullSpeedRate = 1'b0;
        pkt = '{8'h96};
        run_pkt(2, 7, 4);
        fullSpeedRate = 1'b1;
        pkt = '{8'h12, 8'h34, 8'h56};
        run_pkt(3, 6, 0);
        pkt = '{8'h5A, 8'hC3};
        run_pkt(0, 8, 0);
        pkt = '{8'h77};
        run_pkt(4, 4, 0);
        pkt = '{8'hE1, 8'h0F};
        run_pkt(5, 7, 0);
        pkt = '{8'h81, 8'h42, 8'h24};
        run_pkt(6, 7, 0);

        for (int k = 0; k < 40; k++) begin
            n    = $urandom_range(1, 4);
            mode = $urandom_range(0, 6);
            pkt.delete();
            repeat (n) pkt.push_back(8'($urandom));
            fullSpeedRate = 1'($urandom);
            run_pkt(mode,
                    (mode == 4) ? $urandom_range(1, 4) : $urandom_range(5, 8),
                    $urandom_range(1, 7));
        end

        repeat (10) @(negedge clk);
        chk("final_queue", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
